// File: rtl/req_gnt_monitor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : req_gnt_pkg
//  Description : Shared types and helpers for the request/grant monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
package req_gnt_pkg;

    // Per-channel handshake state
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } chan_state_t;

    // Error codes reported on err_type
    typedef enum logic [1:0] {
        OVERLAP  = 2'b00,
        EARLY    = 2'b01,
        LATE     = 2'b10,
        SPURIOUS = 2'b11
    } err_code_t;

    // Population count of up to 16 event bits
    function automatic logic [4:0] popcnt16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'b0000, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/req_gnt_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module      : req_gnt_monitor_if
//  Description : Request/grant bus plus monitor status outputs.
//                master drives the handshake, slave is the monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
interface req_gnt_monitor_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
);
    logic               en;
    logic               clr;
    logic [NCH-1:0]     req;
    logic [NCH-1:0]     gnt;
    logic [NCH-1:0]     err;
    logic [2*NCH-1:0]   err_type;
    logic [NCH-1:0]     err_sticky;
    logic [CNT_W-1:0]   pass_cnt;
    logic [CNT_W-1:0]   fail_cnt;

    modport master (
        output en, clr, req, gnt,
        input  err, err_type, err_sticky, pass_cnt, fail_cnt
    );

    modport slave (
        input  en, clr, req, gnt,
        output err, err_type, err_sticky, pass_cnt, fail_cnt
    );
endinterface
`default_nettype wire

// File: rtl/req_gnt_monitor_chan.sv
`default_nettype none
// ============================================================================
//  Module      : req_gnt_chan
//  Description : One request/grant channel checker. Times each accepted
//                request and classifies the grant as pass, EARLY or LATE;
//                also flags grants with no request and overlapping requests.
//  Revision    : 1.0 - initial release
// ============================================================================
module req_gnt_chan
    import req_gnt_pkg::*;
#(
    parameter int MIN_LAT = 3,
    parameter int MAX_LAT = 3
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_en,
    input  wire logic i_req,
    input  wire logic i_gnt,
    output logic      o_err,
    output err_code_t o_err_type,
    output logic      o_pass_evt,
    output logic      o_fail_evt
);
    localparam int                 c_LAT_W   = $clog2(MAX_LAT + 1);
    localparam logic [c_LAT_W-1:0] c_MIN_LAT = c_LAT_W'(MIN_LAT);
    localparam logic [c_LAT_W-1:0] c_MAX_LAT = c_LAT_W'(MAX_LAT);
    localparam logic [c_LAT_W-1:0] c_ONE     = c_LAT_W'(1);

    chan_state_t          r_state;
    chan_state_t          w_state_nxt;
    logic [c_LAT_W-1:0]   r_lat;
    logic [c_LAT_W-1:0]   w_lat_nxt;
    logic                 r_err;
    err_code_t            r_err_type;
    logic                 w_pass;
    logic                 w_fail;
    err_code_t            w_code;

    // Next-state, latency and event classification for this edge
    always_comb begin
        w_state_nxt = r_state;
        w_lat_nxt   = r_lat;
        w_pass      = 1'b0;
        w_fail      = 1'b0;
        w_code      = OVERLAP;
        case (r_state)
            IDLE: begin
                // A same-edge request wins over the grant: no SPURIOUS
                if (i_req && i_en) begin
                    w_state_nxt = WAIT;
                    w_lat_nxt   = c_ONE;
                end else if (i_gnt) begin
                    w_fail = 1'b1;
                    w_code = SPURIOUS;
                end
            end
            WAIT: begin
                if (i_gnt) begin
                    if (r_lat < c_MIN_LAT) begin
                        w_fail = 1'b1;
                        w_code = EARLY;
                    end else begin
                        w_pass = 1'b1;
                    end
                    // Back-to-back request restarts timing immediately
                    if (i_req && i_en) begin
                        w_state_nxt = WAIT;
                        w_lat_nxt   = c_ONE;
                    end else begin
                        w_state_nxt = IDLE;
                        w_lat_nxt   = '0;
                    end
                end else if (r_lat == c_MAX_LAT) begin
                    // Timeout takes priority over a coincident overlap
                    w_fail      = 1'b1;
                    w_code      = LATE;
                    w_state_nxt = IDLE;
                    w_lat_nxt   = '0;
                end else begin
                    w_lat_nxt = r_lat + c_ONE;
                    if (i_req) begin
                        w_fail = 1'b1;
                        w_code = OVERLAP;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_lat_nxt   = '0;
            end
        endcase
    end

    // State, latency and registered error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_lat      <= '0;
            r_err      <= 1'b0;
            r_err_type <= OVERLAP;
        end else begin
            r_state    <= w_state_nxt;
            r_lat      <= w_lat_nxt;
            r_err      <= w_fail;
            r_err_type <= w_code;
        end
    end

    assign o_err      = r_err;
    assign o_err_type = r_err_type;
    assign o_pass_evt = w_pass;
    assign o_fail_evt = w_fail;

endmodule
`default_nettype wire

// File: rtl/req_gnt_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : req_gnt_monitor
//  Description : NCH-channel request/grant latency monitor with sticky
//                error flags and saturating pass/fail totals.
//  Revision    : 1.0 - initial release
// ============================================================================
module req_gnt_monitor
    import req_gnt_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int MIN_LAT = 3,
    parameter int MAX_LAT = 3,
    parameter int CNT_W   = 8
) (
    input wire logic          clk,
    input wire logic          rst,
    req_gnt_monitor_if.slave  bus
);
    // Sum is wide enough for a saturated count plus up to 16 new events
    localparam int               c_SUM_W   = CNT_W + 6;
    localparam logic [c_SUM_W-1:0] c_CNT_MAX = c_SUM_W'({CNT_W{1'b1}});

    logic [NCH-1:0]     w_err;
    logic [2*NCH-1:0]   w_err_type;
    logic [NCH-1:0]     w_pass_evt;
    logic [NCH-1:0]     w_fail_evt;
    logic [4:0]         w_pass_num;
    logic [4:0]         w_fail_num;
    logic [c_SUM_W-1:0] w_pass_sum;
    logic [c_SUM_W-1:0] w_fail_sum;
    logic [CNT_W-1:0]   w_pass_nxt;
    logic [CNT_W-1:0]   w_fail_nxt;
    logic [CNT_W-1:0]   r_pass_cnt;
    logic [CNT_W-1:0]   r_fail_cnt;
    logic [NCH-1:0]     r_sticky;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        err_code_t w_type;

        req_gnt_chan #(
            .MIN_LAT (MIN_LAT),
            .MAX_LAT (MAX_LAT)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .i_en       (bus.en),
            .i_req      (bus.req[gi]),
            .i_gnt      (bus.gnt[gi]),
            .o_err      (w_err[gi]),
            .o_err_type (w_type),
            .o_pass_evt (w_pass_evt[gi]),
            .o_fail_evt (w_fail_evt[gi])
        );

        assign w_err_type[2*gi +: 2] = w_type;
    end

    // Saturating totals; clear drops the old value but keeps this edge's events
    always_comb begin
        w_pass_num = popcnt16(16'(w_pass_evt));
        w_fail_num = popcnt16(16'(w_fail_evt));
        w_pass_sum = (bus.clr ? '0 : c_SUM_W'(r_pass_cnt)) + c_SUM_W'(w_pass_num);
        w_fail_sum = (bus.clr ? '0 : c_SUM_W'(r_fail_cnt)) + c_SUM_W'(w_fail_num);
        w_pass_nxt = (w_pass_sum > c_CNT_MAX) ? {CNT_W{1'b1}} : w_pass_sum[CNT_W-1:0];
        w_fail_nxt = (w_fail_sum > c_CNT_MAX) ? {CNT_W{1'b1}} : w_fail_sum[CNT_W-1:0];
    end

    // Counter and sticky-flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_sticky   <= '0;
        end else begin
            r_pass_cnt <= w_pass_nxt;
            r_fail_cnt <= w_fail_nxt;
            r_sticky   <= bus.clr ? w_fail_evt : (r_sticky | w_fail_evt);
        end
    end

    assign bus.err        = w_err;
    assign bus.err_type   = w_err_type;
    assign bus.err_sticky = r_sticky;
    assign bus.pass_cnt   = r_pass_cnt;
    assign bus.fail_cnt   = r_fail_cnt;

endmodule
`default_nettype wire

// File: tb/tb_req_gnt_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_req_gnt_monitor
//  Description : Self-checking bench for req_gnt_monitor: three instances
//                (defaults, MIN_LAT=2/MAX_LAT=4, CNT_W=2) against a
//                timestamp-based reference model plus literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_req_gnt_monitor;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   chk_on   = 1'b0;

    req_gnt_monitor_if #(.NCH(4), .CNT_W(8)) bus0 ();
    req_gnt_monitor_if #(.NCH(4), .CNT_W(8)) bus1 ();
    req_gnt_monitor_if #(.NCH(4), .CNT_W(2)) bus2 ();

    req_gnt_monitor #(.NCH(4), .MIN_LAT(3), .MAX_LAT(3), .CNT_W(8)) u_dut0 (
        .clk (clk), .rst (rst), .bus (bus0));
    req_gnt_monitor #(.NCH(4), .MIN_LAT(2), .MAX_LAT(4), .CNT_W(8)) u_dut1 (
        .clk (clk), .rst (rst), .bus (bus1));
    req_gnt_monitor #(.NCH(4), .MIN_LAT(3), .MAX_LAT(3), .CNT_W(2)) u_dut2 (
        .clk (clk), .rst (rst), .bus (bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flattened views of the three instances
    logic [3:0] req_v [3];
    logic [3:0] gnt_v [3];
    logic       en_v  [3];
    logic       clr_v [3];
    logic [3:0] err_v [3];
    logic [7:0] typ_v [3];
    logic [3:0] stk_v [3];
    logic [7:0] pas_v [3];
    logic [7:0] fai_v [3];

    assign req_v[0] = bus0.req;  assign gnt_v[0] = bus0.gnt;
    assign req_v[1] = bus1.req;  assign gnt_v[1] = bus1.gnt;
    assign req_v[2] = bus2.req;  assign gnt_v[2] = bus2.gnt;
    assign en_v[0]  = bus0.en;   assign clr_v[0] = bus0.clr;
    assign en_v[1]  = bus1.en;   assign clr_v[1] = bus1.clr;
    assign en_v[2]  = bus2.en;   assign clr_v[2] = bus2.clr;
    assign err_v[0] = bus0.err;  assign typ_v[0] = bus0.err_type;
    assign err_v[1] = bus1.err;  assign typ_v[1] = bus1.err_type;
    assign err_v[2] = bus2.err;  assign typ_v[2] = bus2.err_type;
    assign stk_v[0] = bus0.err_sticky;
    assign stk_v[1] = bus1.err_sticky;
    assign stk_v[2] = bus2.err_sticky;
    assign pas_v[0] = bus0.pass_cnt;  assign fai_v[0] = bus0.fail_cnt;
    assign pas_v[1] = bus1.pass_cnt;  assign fai_v[1] = bus1.fail_cnt;
    assign pas_v[2] = {6'b0, bus2.pass_cnt};
    assign fai_v[2] = {6'b0, bus2.fail_cnt};

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== 32'(exp)) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // A request accepted at edge t is answered at edge n with latency n-t.
    int min_lat [3] = '{3, 2, 3};
    int max_lat [3] = '{3, 4, 3};
    int cnt_max [3] = '{255, 255, 3};
    int edge_n = 0;
    bit pend   [3][4];
    int t_acc  [3][4];
    bit m_err  [3][4];
    int m_typ  [3][4];
    bit m_stk  [3][4];
    int m_pass [3];
    int m_fail [3];

    always @(posedge clk) begin
        edge_n = edge_n + 1;
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                for (int c = 0; c < 4; c++) begin
                    pend[d][c] = 1'b0; m_err[d][c] = 1'b0;
                    m_typ[d][c] = 0;   m_stk[d][c] = 1'b0;
                end
                m_pass[d] = 0;
                m_fail[d] = 0;
            end else begin
                int np, nf;
                np = 0; nf = 0;
                for (int c = 0; c < 4; c++) begin
                    bit r, g, e, p;
                    int code, lat;
                    r = req_v[d][c]; g = gnt_v[d][c];
                    e = 1'b0; p = 1'b0; code = 0;
                    lat = edge_n - t_acc[d][c];
                    if (pend[d][c]) begin
                        if (g) begin
                            if (lat < min_lat[d]) begin e = 1'b1; code = 1; end
                            else p = 1'b1;
                            pend[d][c] = r && en_v[d];
                            t_acc[d][c] = edge_n;
                        end else if (lat >= max_lat[d]) begin
                            e = 1'b1; code = 2; pend[d][c] = 1'b0;
                        end else if (r) begin
                            e = 1'b1; code = 0;
                        end
                    end else if (r && en_v[d]) begin
                        pend[d][c] = 1'b1; t_acc[d][c] = edge_n;
                    end else if (g) begin
                        e = 1'b1; code = 3;
                    end
                    m_err[d][c] = e;
                    m_typ[d][c] = code;
                    m_stk[d][c] = (clr_v[d] ? 1'b0 : m_stk[d][c]) | e;
                    np += int'(p);
                    nf += int'(e);
                end
                if (clr_v[d]) begin m_pass[d] = 0; m_fail[d] = 0; end
                m_pass[d] = (m_pass[d] + np > cnt_max[d]) ? cnt_max[d] : m_pass[d] + np;
                m_fail[d] = (m_fail[d] + nf > cnt_max[d]) ? cnt_max[d] : m_fail[d] + nf;
            end
        end
    end

    // Compare every instance against the model once per cycle
    always @(negedge clk) begin
        if (chk_on) begin
            for (int d = 0; d < 3; d++) begin
                int e_err, e_stk;
                e_err = 0; e_stk = 0;
                for (int c = 0; c < 4; c++) begin
                    e_err |= int'(m_err[d][c]) << c;
                    e_stk |= int'(m_stk[d][c]) << c;
                    if (m_err[d][c])
                        chk($sformatf("u%0d err_type[%0d] t=%0t", d, c, $time),
                            32'(typ_v[d][2*c +: 2]), m_typ[d][c]);
                end
                chk($sformatf("u%0d err t=%0t", d, $time), 32'(err_v[d]), e_err);
                chk($sformatf("u%0d sticky t=%0t", d, $time), 32'(stk_v[d]), e_stk);
                chk($sformatf("u%0d pass_cnt t=%0t", d, $time), 32'(pas_v[d]), m_pass[d]);
                chk($sformatf("u%0d fail_cnt t=%0t", d, $time), 32'(fai_v[d]), m_fail[d]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic tickn(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set0(input logic [3:0] r, input logic [3:0] g);
        bus0.req = r; bus0.gnt = g;
    endtask
    task automatic set1(input logic [3:0] r, input logic [3:0] g);
        bus1.req = r; bus1.gnt = g;
    endtask
    task automatic set2(input logic [3:0] r, input logic [3:0] g);
        bus2.req = r; bus2.gnt = g;
    endtask

    initial begin
        rst = 1'b1;
        bus0.en = 1'b1; bus0.clr = 1'b0; set0(4'h0, 4'h0);
        bus1.en = 1'b1; bus1.clr = 1'b0; set1(4'h0, 4'h0);
        bus2.en = 1'b1; bus2.clr = 1'b0; set2(4'h0, 4'h0);
        tick();
        chk_on = 1'b1;
        tick();
        rst = 1'b0;
        chk("reset pass_cnt", 32'(bus0.pass_cnt), 0);
        chk("reset fail_cnt", 32'(bus0.fail_cnt), 0);
        chk("reset err", 32'(bus0.err), 0);
        chk("reset sticky", 32'(bus0.err_sticky), 0);

        // Legal handshake at exactly k+3
        set0(4'b0001, 4'h0); tick();
        set0(4'h0, 4'h0);    tickn(2);
        set0(4'h0, 4'b0001); tick();
        chk("pass at k+3 pass_cnt", 32'(bus0.pass_cnt), 1);
        chk("pass at k+3 err", 32'(bus0.err), 0);
        set0(4'h0, 4'h0); tick();

        // Early grant at k+2 on channel 1
        set0(4'b0010, 4'h0); tick();
        set0(4'h0, 4'h0);    tick();
        set0(4'h0, 4'b0010); tick();
        chk("early err", 32'(bus0.err), 2);
        chk("early code", 32'(bus0.err_type[3:2]), 1);
        chk("early fail_cnt", 32'(bus0.fail_cnt), 1);
        chk("early sticky", 32'(bus0.err_sticky), 2);
        set0(4'h0, 4'h0); tick();
        chk("err one cycle only", 32'(bus0.err), 0);

        // Missing grant on channel 2: LATE seen after edge k+3
        set0(4'b0100, 4'h0); tick();
        set0(4'h0, 4'h0);    tickn(2);
        chk("no late before max", 32'(bus0.err), 0);
        tick();
        chk("late err", 32'(bus0.err), 4);
        chk("late code", 32'(bus0.err_type[5:4]), 2);
        tick();
        // Channel 2 idle again: a fresh request passes
        set0(4'b0100, 4'h0); tick();
        set0(4'h0, 4'h0);    tickn(2);
        set0(4'h0, 4'b0100); tick();
        chk("after late pass_cnt", 32'(bus0.pass_cnt), 2);
        set0(4'h0, 4'h0); tick();

        // Spurious grant on channel 3, then clear
        set0(4'h0, 4'b1000); tick();
        chk("spurious code", 32'(bus0.err_type[7:6]), 3);
        chk("spurious sticky", 32'(bus0.err_sticky), 4'b1110);
        set0(4'h0, 4'h0); bus0.clr = 1'b1; tick();
        bus0.clr = 1'b0;
        chk("clr sticky", 32'(bus0.err_sticky), 0);
        chk("clr fail_cnt", 32'(bus0.fail_cnt), 0);

        // All four channels pass on one edge
        set0(4'b1111, 4'h0); tick();
        set0(4'h0, 4'h0);    tickn(2);
        set0(4'h0, 4'b1111); tick();
        chk("quad pass_cnt", 32'(bus0.pass_cnt), 4);
        set0(4'h0, 4'h0); tick();

        // Overlapping request keeps the original timing
        set0(4'b0001, 4'h0); tick();
        tick();
        chk("overlap err", 32'(bus0.err), 1);
        chk("overlap code", 32'(bus0.err_type[1:0]), 0);
        set0(4'h0, 4'h0);    tick();
        set0(4'h0, 4'b0001); tick();
        chk("overlap then pass", 32'(bus0.pass_cnt), 5);
        set0(4'h0, 4'h0); tick();

        // Back-to-back request on the grant edge
        set0(4'b0010, 4'h0);    tick();
        set0(4'h0, 4'h0);       tickn(2);
        set0(4'b0010, 4'b0010); tick();
        set0(4'h0, 4'h0);       tickn(2);
        set0(4'h0, 4'b0010);    tick();
        chk("back-to-back pass_cnt", 32'(bus0.pass_cnt), 7);
        set0(4'h0, 4'h0); tick();

        // Request and grant together from idle: request only
        set0(4'b0100, 4'b0100); tick();
        chk("idle req+gnt no err", 32'(bus0.err), 0);
        set0(4'h0, 4'h0);       tickn(2);
        set0(4'h0, 4'b0100);    tick();
        chk("idle req+gnt pass", 32'(bus0.pass_cnt), 8);
        set0(4'h0, 4'h0); tick();

        // Disable: outstanding request still completes, new ones ignored
        set0(4'b1000, 4'h0); tick();
        bus0.en = 1'b0;
        set0(4'h0, 4'h0);    tickn(2);
        set0(4'h0, 4'b1000); tick();
        chk("en low completes", 32'(bus0.pass_cnt), 9);
        set0(4'b0100, 4'h0); tick();
        set0(4'h0, 4'h0);    tickn(4);
        chk("en low blocks", 32'(bus0.fail_cnt), 1);
        bus0.en = 1'b1;

        // Clear coinciding with a pass counts the pass
        set0(4'b0001, 4'h0); tick();
        set0(4'h0, 4'h0);    tickn(2);
        set0(4'h0, 4'b0001); bus0.clr = 1'b1; tick();
        bus0.clr = 1'b0;
        chk("clr+event pass_cnt", 32'(bus0.pass_cnt), 1);
        chk("clr+event fail_cnt", 32'(bus0.fail_cnt), 0);
        set0(4'h0, 4'h0); tick();

        // MIN_LAT=2, MAX_LAT=4: pass at k+4 with new request, pass at k+6
        set1(4'b0001, 4'h0);    tick();
        set1(4'h0, 4'h0);       tickn(3);
        set1(4'b0001, 4'b0001); tick();
        set1(4'h0, 4'h0);       tick();
        set1(4'h0, 4'b0001);    tick();
        chk("u1 two passes", 32'(bus1.pass_cnt), 2);
        chk("u1 no fail", 32'(bus1.fail_cnt), 0);
        set1(4'b0001, 4'h0);    tick();
        set1(4'h0, 4'b0001);    tick();
        chk("u1 early at lat1", 32'(bus1.err_type[1:0]), 1);
        set1(4'h0, 4'h0); tick();

        // CNT_W=2 saturation
        set2(4'b1111, 4'h0); tick();
        set2(4'h0, 4'h0);    tickn(2);
        set2(4'h0, 4'b1111); tick();
        chk("u2 saturated", 32'(bus2.pass_cnt), 3);
        set2(4'b0001, 4'h0); tick();
        set2(4'h0, 4'h0);    tickn(2);
        set2(4'h0, 4'b0001); tick();
        chk("u2 stays saturated", 32'(bus2.pass_cnt), 3);
        set2(4'h0, 4'h0); tick();

        // Reset mid-wait abandons the request silently
        set0(4'b0010, 4'h0); tick();
        set0(4'h0, 4'h0); rst = 1'b1; tick();
        rst = 1'b0; tickn(4);
        chk("rst mid-wait fail_cnt", 32'(bus0.fail_cnt), 0);
        chk("rst mid-wait pass_cnt", 32'(bus0.pass_cnt), 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/req_gnt_monitor.md
REQ_GNT_MONITOR -- requirements
Module: req_gnt_monitor

Interface
REQ-001 SHALL have parameter NCH, default 4, number of independent req/gnt channels (1..16).
REQ-002 SHALL have parameter MIN_LAT, default 3, minimum legal grant latency in clk edges (>=1).
REQ-003 SHALL have parameter MAX_LAT, default 3, maximum legal grant latency in clk edges (MIN_LAT..255).
REQ-004 SHALL have parameter CNT_W, default 8, width of the pass/fail counters.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 en  input  1  monitoring enable; when low, no new requests are accepted.
REQ-009 clr  input  1  synchronous clear of sticky flags and counters.
REQ-010 req  input  NCH  per-channel request, sampled at posedge clk.
REQ-011 gnt  input  NCH  per-channel grant, sampled at posedge clk.
REQ-012 err  output  NCH  one-cycle error pulse per channel.
REQ-013 err_type  output  2*NCH  per-channel error code, valid while err bit high.
REQ-014 err_sticky  output  NCH  latched error per channel.
REQ-015 pass_cnt  output  CNT_W  total of legal handshakes, all channels.
REQ-016 fail_cnt  output  CNT_W  total of errors, all channels.

Function
REQ-017 Each channel SHALL run an FSM with states IDLE, WAIT.
REQ-018 IDLE, req=1, en=1 at edge k: go to WAIT, latency counter lat<=1.
REQ-019 WAIT, gnt=0: if lat==MAX_LAT, flag LATE (code 2'b10) and go to IDLE; else lat<=lat+1.
REQ-020 WAIT, gnt=1: if lat<MIN_LAT, flag EARLY (code 2'b01); else count pass; either way, leave WAIT.
REQ-021 So with defaults, req at edge k passes only with gnt at edge k+3.
REQ-022 IDLE, gnt=1 and no same-edge request SHALL flag SPURIOUS (code 2'b11).
REQ-023 WAIT, req=1 while gnt=0 SHALL flag OVERLAP (code 2'b00); the original request keeps being timed.
REQ-024 WAIT, gnt=1 and req=1 on the same edge: resolve the grant per REQ-020, then re-enter WAIT with lat<=1 (back-to-back request, no error).
REQ-025 IDLE, req=1 and gnt=1 on the same edge: accept the request only; no SPURIOUS.
REQ-026 err and err_type SHALL be registered: high for exactly the cycle after the detecting edge.
REQ-027 err_sticky[i] SHALL set with err[i] and hold until clr or rst.
REQ-028 pass_cnt and fail_cnt SHALL each add the number of same-cycle events across channels.
REQ-029 pass_cnt and fail_cnt SHALL saturate at 2**CNT_W-1.
REQ-030 clr SHALL zero counters and sticky flags and SHALL NOT affect FSMs.
REQ-031 If clr coincides with an event, the event SHALL be counted after the clear (result = event count).
REQ-032 en=0 SHALL only block new requests; channels in WAIT still complete.
REQ-033 The lat counter width SHALL be $clog2(MAX_LAT+1).

Reset
REQ-034 rst SHALL force all FSMs to IDLE, lat to 0, and err, err_type, err_sticky, pass_cnt, fail_cnt to 0 at the next edge.
REQ-035 rst mid-WAIT SHALL abandon the outstanding request silently (no LATE).

Structure
REQ-036 Package req_gnt_pkg SHALL hold the state enum (IDLE, WAIT) and the error-code enum (OVERLAP, EARLY, LATE, SPURIOUS).
REQ-037 Sub-module req_gnt_chan SHALL implement one channel FSM and be generated NCH times.
REQ-038 The top level SHALL hold the counters, sticky flags and the population-count adders.

Verification
REQ-039 Defaults: req[0] high one cycle at edge k, gnt[0] at k+3 -> no err; pass_cnt=1.
REQ-040 Defaults: req[1] at k, gnt[1] at k+2 -> err[1] at k+3, err_type=EARLY; fail_cnt=1; err_sticky[1]=1.
REQ-041 Defaults: req[2] at k, no gnt -> err[2] LATE at k+4; channel back in IDLE.
REQ-042 MIN_LAT=2, MAX_LAT=4: gnt[0] at k+4 with new req[0] on the same edge, then gnt at k+6 -> pass_cnt=2, no err.
REQ-043 gnt[3] with channel idle -> SPURIOUS; then clr -> err_sticky=0, fail_cnt=0.
REQ-044 All 4 channels pass on the same edge -> pass_cnt +4; CNT_W=2 run of 5 passes -> pass_cnt=3 (saturated).
